// File: rtl/tsys_stamper.sv
// Event timestamp scheduler: per-source capture of the 64-bit system timestamp,
// round-robin serialisation into a FIFO, and a 16-bit register window for readout.
module tsys_stamper #(
    parameter int NREQ  = 4,
    parameter int DEPTH = 16
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic [NREQ-1:0] req_i,
    input  logic [63:0]     tsys_i,
    input  logic            reg_we_i,
    input  logic [7:0]      reg_addr_i,
    input  logic [15:0]     reg_data_i,
    output logic [15:0]     reg_data_o,
    output logic            irq_o
);

    localparam int SW = $clog2(NREQ);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = SW + 64;

    localparam logic [7:0] ADDR_STATUS  = 8'h00;
    localparam logic [7:0] ADDR_ENABLE  = 8'h01;
    localparam logic [7:0] ADDR_CMD     = 8'h02;
    localparam logic [7:0] ADDR_HEAD0   = 8'h03;
    localparam logic [7:0] ADDR_HEAD1   = 8'h04;
    localparam logic [7:0] ADDR_HEAD2   = 8'h05;
    localparam logic [7:0] ADDR_HEAD3   = 8'h06;
    localparam logic [7:0] ADDR_HEADSRC = 8'h07;
    localparam logic [7:0] ADDR_DROPS   = 8'h08;

    localparam logic [SW-1:0] LAST_RST = SW'(NREQ - 1);

    // Architectural state
    logic [EW-1:0]   mem [DEPTH];
    logic [AW:0]     wr_ptr, rd_ptr;
    logic [NREQ-1:0] enable;
    logic [NREQ-1:0] pend;
    logic [63:0]     stamp [NREQ];
    logic [SW-1:0]   last;
    logic [15:0]     drops;
    logic            irq;

    // Derived signals
    logic            empty, full;
    logic [AW:0]     fill;
    logic            cmd_we, pop_cmd, clr_cmd, pop_ok, push_ok;
    logic            gnt_valid;
    logic [SW-1:0]   gnt_idx;
    logic [NREQ-1:0] gnt_vec, accept, latch, drop;
    logic [NREQ-1:0] pend_next;
    logic [4:0]      drop_cnt;
    logic [16:0]     drops_sum;
    logic [15:0]     drops_next;
    logic [AW:0]     wr_ptr_next, rd_ptr_next;
    logic [EW-1:0]   head_entry;
    logic [63:0]     head_stamp;
    logic [SW-1:0]   head_src;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign fill  = wr_ptr - rd_ptr;

    // A POP and a CLR are distinct data values, so at most one decodes per write.
    assign cmd_we  = reg_we_i && (reg_addr_i == ADDR_CMD);
    assign pop_cmd = cmd_we && (reg_data_i == 16'h0001);
    assign clr_cmd = cmd_we && (reg_data_i == 16'h0002);
    assign pop_ok  = pop_cmd && !empty;
    // A same-cycle POP frees a slot, so a full FIFO can still take a push.
    assign push_ok = (!full || pop_ok) && !clr_cmd;

    // Round-robin grant: first pending source after 'last', wrapping.
    always_comb begin
        logic [SW:0] pos;
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        pos       = '0;
        if (push_ok) begin
            for (int k = 1; k <= NREQ; k++) begin
                pos = {1'b0, last} + (SW+1)'(k);
                if (pos >= (SW+1)'(NREQ)) pos = pos - (SW+1)'(NREQ);
                if (!gnt_valid && pend[pos[SW-1:0]]) begin
                    gnt_valid = 1'b1;
                    gnt_idx   = pos[SW-1:0];
                end
            end
        end
    end

    assign gnt_vec = gnt_valid ? (NREQ'(1) << gnt_idx) : '0;

    // Capture decisions: latch into a free (or just-granted) slot, otherwise drop.
    always_comb begin
        accept   = req_i & enable & {NREQ{~clr_cmd}};
        latch    = accept & (~pend | gnt_vec);
        drop     = accept & pend & ~gnt_vec;
        drop_cnt = '0;
        for (int i = 0; i < NREQ; i++) begin
            drop_cnt = drop_cnt + 5'(drop[i]);
        end
        pend_next  = clr_cmd ? '0 : ((pend & ~gnt_vec) | accept);
        drops_sum  = {1'b0, drops} + 17'(drop_cnt);
        drops_next = clr_cmd ? 16'h0000 : (drops_sum[16] ? 16'hFFFF : drops_sum[15:0]);
    end

    assign wr_ptr_next = clr_cmd ? '0 : wr_ptr + (AW+1)'(gnt_valid);
    assign rd_ptr_next = clr_cmd ? '0 : rd_ptr + (AW+1)'(pop_ok);

    // Control state: pointers, pend bits, enables, arbiter history, drop counter, irq.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            pend   <= '0;
            enable <= '0;
            last   <= LAST_RST;
            drops  <= '0;
            irq    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            wr_ptr <= wr_ptr_next;
            rd_ptr <= rd_ptr_next;
            pend   <= pend_next;
            drops  <= drops_next;
            irq    <= (wr_ptr_next != rd_ptr_next);
            if (reg_we_i && (reg_addr_i == ADDR_ENABLE)) begin
                enable <= reg_data_i[NREQ-1:0];
            end
            if (clr_cmd) begin
                last <= LAST_RST;
            end else if (gnt_valid) begin
                last <= gnt_idx;
            end
        end
    end

    // Per-source stamp holding registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < NREQ; i++) stamp[i] <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (latch[i]) stamp[i] <= tsys_i;
            end
        end
    end

    // FIFO storage write; the granted slot is written with its pre-edge stamp.
    // NOTE: storage has no reset; empty-gating of the HEAD reads hides stale contents.
    always_ff @(posedge clk_i) begin
        if (gnt_valid) begin
            mem[wr_ptr[AW-1:0]] <= {gnt_idx, stamp[gnt_idx]};
        end
    end

    assign head_entry = mem[rd_ptr[AW-1:0]];
    assign head_stamp = head_entry[63:0];
    assign head_src   = head_entry[EW-1:64];
    assign irq_o      = irq;

    // Register read mux, combinational from the address.
    always_comb begin
        reg_data_o = 16'hF001;
        case (reg_addr_i)
            ADDR_STATUS:  reg_data_o = {empty, full, 7'b0, 7'(fill)};
            ADDR_ENABLE:  reg_data_o = 16'(enable);
            ADDR_CMD:     reg_data_o = 16'h0000;
            ADDR_HEAD0:   reg_data_o = empty ? 16'h0000 : head_stamp[15:0];
            ADDR_HEAD1:   reg_data_o = empty ? 16'h0000 : head_stamp[31:16];
            ADDR_HEAD2:   reg_data_o = empty ? 16'h0000 : head_stamp[47:32];
            ADDR_HEAD3:   reg_data_o = empty ? 16'h0000 : head_stamp[63:48];
            ADDR_HEADSRC: reg_data_o = empty ? 16'h0000 : 16'(head_src);
            ADDR_DROPS:   reg_data_o = drops;
            default:      reg_data_o = 16'hF001;
        endcase
    end

endmodule

// File: tb/tb_tsys_stamper.sv
// Directed bench for tsys_stamper: hand-computed register reads after each step.
module tb_tsys_stamper;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic [3:0]  req_i = '0;
    logic [63:0] tsys_i = '0;
    logic        reg_we_i = 1'b0;
    logic [7:0]  reg_addr_i = '0;
    logic [15:0] reg_data_i = '0;
    logic [15:0] reg_data_o;
    logic        irq_o;

    int errors = 0;
    int checks = 0;

    tsys_stamper #(.NREQ(4), .DEPTH(16)) dut (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .req_i      (req_i),
        .tsys_i     (tsys_i),
        .reg_we_i   (reg_we_i),
        .reg_addr_i (reg_addr_i),
        .reg_data_i (reg_data_i),
        .reg_data_o (reg_data_o),
        .irq_o      (irq_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rd_check(input string tag, input logic [7:0] addr, input logic [15:0] exp);
        reg_addr_i = addr;
        #1;
        check(tag, reg_data_o, exp);
    endtask

    task automatic reg_write(input logic [7:0] addr, input logic [15:0] data);
        reg_we_i   = 1'b1;
        reg_addr_i = addr;
        reg_data_i = data;
        tick();
        reg_we_i   = 1'b0;
        reg_data_i = '0;
    endtask

    task automatic pulse(input logic [3:0] mask, input logic [63:0] ts);
        req_i  = mask;
        tsys_i = ts;
        tick();
        req_i  = '0;
    endtask

    initial begin
        logic [15:0] order_a [4];
        logic [15:0] order_b [4];
        order_a = '{16'd0, 16'd1, 16'd2, 16'd3};
        order_b = '{16'd2, 16'd3, 16'd0, 16'd1};

        // Reset state
        tick(); tick();
        rst_n_i = 1'b1;
        tick();
        rd_check("rst_status", 8'h00, 16'h8000);
        rd_check("rst_head0", 8'h03, 16'h0000);
        rd_check("rst_badaddr", 8'h09, 16'hF001);
        rd_check("rst_enable", 8'h01, 16'h0000);
        rd_check("rst_drops", 8'h08, 16'h0000);
        check("rst_irq", {15'b0, irq_o}, 16'h0000);

        // Single capture on source 0 with a full 64-bit stamp
        reg_write(8'h01, 16'h0001);
        pulse(4'h1, 64'h0000_0001_2345_6789);
        rd_check("lat_not_yet", 8'h00, 16'h8000);
        tick();
        rd_check("one_status", 8'h00, 16'h0001);
        check("one_irq", {15'b0, irq_o}, 16'h0001);
        rd_check("one_head0", 8'h03, 16'h6789);
        rd_check("one_head1", 8'h04, 16'h2345);
        rd_check("one_head2", 8'h05, 16'h0001);
        rd_check("one_head3", 8'h06, 16'h0000);
        rd_check("one_src", 8'h07, 16'h0000);
        reg_write(8'h02, 16'h0001);
        rd_check("pop_status", 8'h00, 16'h8000);
        check("pop_irq", {15'b0, irq_o}, 16'h0000);

        // All four at once after CLR: order 0,1,2,3
        reg_write(8'h01, 16'h000F);
        rd_check("enable_rb", 8'h01, 16'h000F);
        reg_write(8'h02, 16'h0002);
        pulse(4'hF, 64'h0000_0000_0000_0100);
        tick(); tick(); tick(); tick();
        rd_check("rr_a_status", 8'h00, 16'h0004);
        rd_check("rr_a_head0", 8'h03, 16'h0100);
        for (int i = 0; i < 4; i++) begin
            rd_check("rr_a_src", 8'h07, order_a[i]);
            reg_write(8'h02, 16'h0001);
        end
        rd_check("rr_a_drained", 8'h00, 16'h8000);

        // Move last to 1, then all four again: order 2,3,0,1
        pulse(4'h3, 64'h0000_0000_0000_0200);
        tick(); tick();
        rd_check("rr_b_pre", 8'h00, 16'h0002);
        reg_write(8'h02, 16'h0001);
        reg_write(8'h02, 16'h0001);
        pulse(4'hF, 64'h0000_0000_0000_0300);
        tick(); tick(); tick(); tick();
        rd_check("rr_b_status", 8'h00, 16'h0004);
        for (int i = 0; i < 4; i++) begin
            rd_check("rr_b_src", 8'h07, order_b[i]);
            reg_write(8'h02, 16'h0001);
        end

        // Fill to full on source 2, one held in pend, then a drop
        reg_write(8'h02, 16'h0002);
        reg_write(8'h01, 16'h0004);
        for (int k = 0; k < 17; k++) begin
            pulse(4'h4, 64'h1000 + 64'(k));
            tick(); tick();
        end
        tick(); tick();
        rd_check("full_status", 8'h00, 16'h4010);
        rd_check("full_head0", 8'h03, 16'h1000);
        rd_check("full_src", 8'h07, 16'h0002);
        rd_check("full_drops0", 8'h08, 16'h0000);
        pulse(4'h4, 64'h2000);
        rd_check("drop_count", 8'h08, 16'h0001);
        rd_check("drop_status", 8'h00, 16'h4010);
        reg_write(8'h02, 16'h0001);
        rd_check("popfull_status", 8'h00, 16'h4010);
        rd_check("popfull_head0", 8'h03, 16'h1001);
        for (int k = 0; k < 15; k++) reg_write(8'h02, 16'h0001);
        rd_check("held_status", 8'h00, 16'h0001);
        rd_check("held_head0", 8'h03, 16'h1010);

        // CLR with a same-cycle request on source 1
        reg_write(8'h01, 16'h0002);
        reg_we_i   = 1'b1;
        reg_addr_i = 8'h02;
        reg_data_i = 16'h0002;
        req_i      = 4'h2;
        tsys_i     = 64'h3000;
        tick();
        reg_we_i   = 1'b0;
        reg_data_i = '0;
        req_i      = '0;
        rd_check("clr_status", 8'h00, 16'h8000);
        rd_check("clr_drops", 8'h08, 16'h0000);
        check("clr_irq", {15'b0, irq_o}, 16'h0000);
        tick(); tick(); tick();
        rd_check("clr_late", 8'h00, 16'h8000);

        // Re-request in the grant cycle: no drop, newer stamp second
        reg_write(8'h01, 16'h0001);
        pulse(4'h1, 64'h000A);
        pulse(4'h1, 64'h000B);
        tick();
        rd_check("regrant_status", 8'h00, 16'h0002);
        rd_check("regrant_drops", 8'h08, 16'h0000);
        rd_check("regrant_first", 8'h03, 16'h000A);
        reg_write(8'h02, 16'h0001);
        rd_check("regrant_second", 8'h03, 16'h000B);

        // Asynchronous reset mid-operation with one entry left
        rst_n_i = 1'b0;
        #1;
        rd_check("arst_status", 8'h00, 16'h8000);
        rd_check("arst_enable", 8'h01, 16'h0000);
        check("arst_irq", {15'b0, irq_o}, 16'h0000);
        tick();
        rst_n_i = 1'b1;
        tick();
        rd_check("arst_after", 8'h00, 16'h8000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tsys_stamper.md
# tsys_stamper

Event timestamp scheduler for the 64-bit system timestamp counter. Up to NREQ event sources (trigger inputs, busy edges, strobe markers) each request a timestamp. The block latches `tsys_i` for each source in the request cycle. A round-robin arbiter serialises the latched stamps into one FIFO, which software drains through the 16-bit register bus used by the other slow-control blocks.

## Interface
Parameters:
- NREQ, 4: number of requesters; range 2..8.
- DEPTH, 16: FIFO entries; power of two, range 4..64.

Ports:
- clk_i  in  1  system clock; the same clock that drives the timestamp counter.
- rst_n_i  in  1  asynchronous, active-low reset.
- req_i  in  NREQ  per-source single-cycle event pulses.
- tsys_i  in  64  running system timestamp.
- reg_we_i  in  1  register write strobe.
- reg_addr_i  in  8  register address.
- reg_data_i  in  16  register write data.
- reg_data_o  out  16  register read data; combinational from `reg_addr_i`.
- irq_o  out  1  registered; 1 while the FIFO is non-empty.

## Operation
Registers:
- 0x00 STATUS (RO): [15] empty, [14] full, [6:0] fill count.
- 0x01 ENABLE (RW): [NREQ-1:0] per-source enable; reset 0; upper bits read 0.
- 0x02 CMD (WO, reads 0): write 0x0001 = POP, 0x0002 = CLR. Any other value is ignored.
- 0x03..0x06 HEAD0..HEAD3: FIFO head stamp bits [15:0], [31:16], [47:32], [63:48]. Read 0 when the FIFO is empty.
- 0x07 HEADSRC: head source index, zero-extended; 0 when empty.
- 0x08 DROPS: 16-bit total dropped-event count; saturates at 0xFFFF.
- Any other address reads 0xF001.

Capture stage, per source i:
- A request is accepted when `req_i[i]` and `ENABLE[i]` are both 1.
- Accepted request with pend[i] = 0: stamp[i] <= `tsys_i`, pend[i] <= 1.
- Accepted request with pend[i] = 1 and source i not granted this cycle: event dropped, DROPS += 1, stamp[i] unchanged.
- Accepted request with pend[i] = 1 and source i granted this cycle: new stamp latched, pend[i] stays 1, no drop.
- Disabled sources are ignored and not counted. Clearing an ENABLE bit does not clear an existing pend bit; that stamp is still drained.

Arbiter:
- Push is allowed when the FIFO is not full, or when a POP is accepted in the same cycle.
- When push is allowed, grant one pending source per cycle, round-robin: search from last+1 upward, wrapping.
- last resets to NREQ-1, so source 0 has first priority after reset.
- The grant writes {source index, stamp} into the FIFO and clears the pend bit (unless re-set as described above).
- When the FIFO is full, pend bits are held. Nothing is dropped at the arbiter.

Commands:
- POP: advances the read pointer. Ignored when the FIFO is empty.
- CLR: empties the FIFO, clears all pend bits and DROPS, and resets last to NREQ-1.
- CLR takes precedence over every same-cycle push, request and POP. Requests arriving in the CLR cycle are discarded and not counted.

## Timing
- Reset: FIFO empty, pend = 0, stamps = 0, ENABLE = 0, DROPS = 0, irq_o = 0, last = NREQ-1.
- Reset values as read: `reg_data_o` is 0x8000 at address 0x00.
- Reset asserted mid-operation clears all state immediately, with no partial pop or push.
- Request latency:
  - `req_i` in cycle t captures the value of `tsys_i` present in cycle t.
  - pend is set at edge t+1.
  - Earliest FIFO write is at edge t+2.
  - The entry is readable, and irq_o = 1, from cycle t+2.
- POP or CLR written in cycle t takes effect at edge t+1. HEAD registers show the next entry from cycle t+1.
- Fill count: a push and a POP in the same cycle leave the count unchanged; this is also true when the FIFO is full.
- Pointer arithmetic: pointers are log2(DEPTH)+1 bits and wrap naturally. Full means the MSBs differ and the remaining bits are equal.
- Throughput: one push per cycle. N sources pulsing in the same cycle are all captured and drain over N consecutive cycles.

## Test plan
- Reset, then read 0x00 -> 0x8000. Read 0x03 -> 0x0000. Read 0x09 -> 0xF001. irq_o = 0.
- ENABLE = 0x1, `tsys_i` = 0x0000_0001_2345_6789, pulse req_i[0] -> after 2 cycles, STATUS = 0x0001 and HEAD0..3 = 0x6789, 0x2345, 0x0001, 0x0000. POP -> STATUS = 0x8000.
- ENABLE = 0xF, pulse all four sources in one cycle -> 4 entries with HEADSRC order 0, 1, 2, 3. Repeat starting with last = 1 -> order 2, 3, 0, 1.
- DEPTH = 16, 17 pulses on source 2 spaced 3 cycles apart, no POP -> STATUS = 0x4010 with pend[2] held. A further pulse on source 2 -> DROPS = 1. One POP -> the pending entry enters, count stays 16.
- Request on source 1 in the same cycle as CLR -> STATUS = 0x8000, DROPS = 0, no entry appears later.
- Pulse req_i[0] again in the cycle its pending stamp is granted -> no drop, 2 entries, the second with the newer stamp.
